// File: rtl/multi_io_pkg.sv
// Shared definitions for the FE-I4 readout slice: register offsets, TDC word constants, sequencer states.
// The optional TDC is enabled with the MULTI_IO_TDC_EN macro.
package multi_io_pkg;

    localparam logic [7:0] CMD_RESET_OFF  = 8'd0;
    localparam logic [7:0] CMD_START_OFF  = 8'd1;
    localparam logic [7:0] CMD_EN_OFF     = 8'd2;
    localparam logic [7:0] CMD_SIZE_OFF   = 8'd3;
    localparam logic [7:0] CMD_REPEAT_OFF = 8'd5;
    localparam logic [7:0] CMD_DATA_OFF   = 8'd16;

    localparam logic [2:0] FIFO_CTRL_OFF  = 3'd0;
    localparam logic [2:0] FIFO_COUNT_OFF = 3'd1;
    localparam logic [2:0] FIFO_DATA_OFF  = 3'd4;

    localparam logic [15:0] TDC_ENABLE_OFF = 16'd1;

    localparam logic [3:0]  TDC_HEADER = 4'h4;
    localparam logic [11:0] TOT_MAX    = 12'd4095;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_SEND = 1'b1
    } seq_state_t;

endpackage

// File: rtl/multi_io_if.sv
// 8-bit register bus between the USB bridge (master) and the readout controller (slave).
interface multi_io_if;
    logic [15:0] BUS_ADD;
    logic [7:0]  BUS_DATA_IN;
    logic [7:0]  BUS_DATA_OUT;
    logic        BUS_WR;
    logic        BUS_RD;

    modport master (
        output BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD,
        input  BUS_DATA_OUT
    );

    modport slave (
        input  BUS_ADD, BUS_DATA_IN, BUS_WR, BUS_RD,
        output BUS_DATA_OUT
    );
endinterface

// File: rtl/multi_io_cmd_seq.sv
// Command sequencer: pattern memory, SIZE/REPEAT registers and the MSB-first serialiser onto CMD_DATA.
module multi_io_cmd_seq
    import multi_io_pkg::*;
#(
    parameter int MEM_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel,
    input  logic       wr,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    input  logic       ext_trigger,
    output logic       cmd_data,
    output logic       cmd_ready
);
    localparam int MEM_AW = $clog2(MEM_BYTES);

    logic [7:0]  mem [MEM_BYTES];
    logic        en_ext;
    logic [15:0] size_reg;
    logic [15:0] rep_reg;
    logic [15:0] size_lat;
    logic [15:0] pass_last;
    logic [15:0] bit_cnt, bit_cnt_nxt;
    logic [15:0] pass_cnt, pass_cnt_nxt;
    logic        cmd_data_nxt;
    seq_state_t  state, state_nxt;
    logic [2:0]  trig_sync;
    logic        ext_edge;
    logic        soft_rst;
    logic        start;
    logic [MEM_AW-1:0] mem_idx;

    assign soft_rst  = sel && wr && (addr == CMD_RESET_OFF);
    assign ext_edge  = trig_sync[1] & ~trig_sync[2];
    assign start     = (sel && wr && (addr == CMD_START_OFF)) || (ext_edge && en_ext);
    assign cmd_ready = (state == SEQ_IDLE);
    assign mem_idx   = MEM_AW'(addr - CMD_DATA_OFF);

    // Bit k lives in byte k/8, MSB first within the byte.
    function automatic logic pattern_bit(input logic [MEM_AW+2:0] idx);
        logic [7:0] b;
        b = mem[idx[MEM_AW+2:3]];
        return b[~idx[2:0]];
    endfunction

    always_ff @(posedge clk) begin
        if (sel && wr && (addr >= CMD_DATA_OFF))
            mem[mem_idx] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_ext   <= 1'b0;
            size_reg <= '0;
            rep_reg  <= '0;
        end else if (sel && wr) begin
            case (addr)
                CMD_EN_OFF:             en_ext         <= wdata[0];
                CMD_SIZE_OFF:           size_reg[7:0]  <= wdata;
                CMD_SIZE_OFF + 8'd1:    size_reg[15:8] <= wdata;
                CMD_REPEAT_OFF:         rep_reg[7:0]   <= wdata;
                CMD_REPEAT_OFF + 8'd1:  rep_reg[15:8]  <= wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        pass_cnt_nxt = pass_cnt;
        cmd_data_nxt = cmd_data;
        if (soft_rst) begin
            state_nxt    = SEQ_IDLE;
            cmd_data_nxt = 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    cmd_data_nxt = 1'b0;
                    if (start && (size_reg != 16'd0)) begin
                        state_nxt    = SEQ_SEND;
                        bit_cnt_nxt  = 16'd1;
                        pass_cnt_nxt = 16'd0;
                        cmd_data_nxt = pattern_bit('0);
                    end
                end
                SEQ_SEND: begin
                    if (bit_cnt == size_lat) begin
                        if (pass_cnt == pass_last) begin
                            state_nxt    = SEQ_IDLE;
                            cmd_data_nxt = 1'b0;
                        end else begin
                            pass_cnt_nxt = pass_cnt + 16'd1;
                            bit_cnt_nxt  = 16'd1;
                            cmd_data_nxt = pattern_bit('0);
                        end
                    end else begin
                        cmd_data_nxt = pattern_bit(bit_cnt[MEM_AW+2:0]);
                        bit_cnt_nxt  = bit_cnt + 16'd1;
                    end
                end
                default: begin
                    state_nxt    = SEQ_IDLE;
                    cmd_data_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEQ_IDLE;
            bit_cnt   <= '0;
            pass_cnt  <= '0;
            cmd_data  <= 1'b0;
            size_lat  <= '0;
            pass_last <= '0;
            trig_sync <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            pass_cnt  <= pass_cnt_nxt;
            cmd_data  <= cmd_data_nxt;
            trig_sync <= {trig_sync[1:0], ext_trigger};
            // Transfer parameters are frozen at start so bus writes during SEND wait for the next start.
            if ((state == SEQ_IDLE) && (state_nxt == SEQ_SEND)) begin
                size_lat  <= size_reg;
                pass_last <= (rep_reg == 16'd0) ? 16'd0 : rep_reg - 16'd1;
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        if (addr >= CMD_DATA_OFF) begin
            rdata = mem[mem_idx];
        end else begin
            case (addr)
                CMD_START_OFF:          rdata = {7'b0, cmd_ready};
                CMD_EN_OFF:             rdata = {7'b0, en_ext};
                CMD_SIZE_OFF:           rdata = size_reg[7:0];
                CMD_SIZE_OFF + 8'd1:    rdata = size_reg[15:8];
                CMD_REPEAT_OFF:         rdata = rep_reg[7:0];
                CMD_REPEAT_OFF + 8'd1:  rdata = rep_reg[15:8];
                default:                rdata = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/multi_io_top.sv
// FE-I4 readout controller top: bus decode, command sequencer, MONHIT ToT unit and 32-bit word FIFO.
// Define MULTI_IO_TDC_EN to include the TDC; without it MONHIT is ignored and the FIFO stays empty.
module multi_io_top
    import multi_io_pkg::*;
#(
    parameter int          MEM_BYTES  = 64,
    parameter int          FIFO_DEPTH = 256,
    parameter logic [15:0] CMD_BASE   = 16'h0000,
    parameter logic [15:0] FIFO_BASE  = 16'h8100,
    parameter logic [15:0] TDC_BASE   = 16'h8700
) (
    input  logic       BUS_CLK,
    input  logic       BUS_RST,
    multi_io_if.slave  bus,
    input  logic       EXT_TRIGGER,
    input  logic       MONHIT,
    output logic       CMD_DATA,
    output logic       CMD_READY
);
    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] PTR_ONE = 1;

    logic [15:0] cmd_off, fifo_off;
    logic        cmd_sel, fifo_sel;
    logic [7:0]  cmd_rdata, tdc_rdata, fifo_rdata, rdata_mux;
    logic [2:0]  fifo_reg;

    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW:0] wr_ptr, rd_ptr, fifo_words;
    logic             fifo_empty, fifo_full, fifo_pop, fifo_flush, push_ok;
    logic             overflow;
    logic [23:0]      byte_count;
    logic [15:0]      cnt_snap;
    logic [31:0]      head_word;
    logic             tdc_push;
    logic [31:0]      tdc_word;

    assign cmd_off  = bus.BUS_ADD - CMD_BASE;
    assign fifo_off = bus.BUS_ADD - FIFO_BASE;
    assign cmd_sel  = cmd_off < 16'h0100;
    assign fifo_sel = !cmd_sel && (fifo_off < 16'd8);
    assign fifo_reg = fifo_off[2:0];

    multi_io_cmd_seq #(
        .MEM_BYTES (MEM_BYTES)
    ) u_cmd_seq (
        .clk         (BUS_CLK),
        .rst         (BUS_RST),
        .sel         (cmd_sel),
        .wr          (bus.BUS_WR),
        .addr        (cmd_off[7:0]),
        .wdata       (bus.BUS_DATA_IN),
        .rdata       (cmd_rdata),
        .ext_trigger (EXT_TRIGGER),
        .cmd_data    (CMD_DATA),
        .cmd_ready   (CMD_READY)
    );

`ifdef MULTI_IO_TDC_EN
    logic [15:0] tdc_off;
    logic        tdc_sel, enable_wr;
    logic [2:0]  mon_sync;
    logic        mon_rise, mon_fall;
    logic        tdc_enable, armed;
    logic [15:0] evt_cnt;
    logic [11:0] tot;

    function automatic logic [11:0] tot_inc(input logic [11:0] t);
        return (t == TOT_MAX) ? TOT_MAX : t + 12'd1;
    endfunction

    assign tdc_off   = bus.BUS_ADD - TDC_BASE;
    assign tdc_sel   = !cmd_sel && !fifo_sel && (tdc_off < 16'd2);
    assign enable_wr = bus.BUS_WR && tdc_sel && (tdc_off == TDC_ENABLE_OFF);
    assign mon_rise  = mon_sync[1] & ~mon_sync[2];
    assign mon_fall  = ~mon_sync[1] & mon_sync[2];
    assign tdc_push  = tdc_enable && armed && mon_fall;
    assign tdc_word  = {TDC_HEADER, evt_cnt, tot};
    assign tdc_rdata = (tdc_sel && (tdc_off == TDC_ENABLE_OFF)) ? {7'b0, tdc_enable} : 8'h00;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            mon_sync   <= '0;
            tdc_enable <= 1'b0;
            armed      <= 1'b0;
            evt_cnt    <= '0;
            tot        <= '0;
        end else begin
            mon_sync <= {mon_sync[1:0], MONHIT};
            if (enable_wr)
                tdc_enable <= bus.BUS_DATA_IN[0];
            if (enable_wr && bus.BUS_DATA_IN[0])
                evt_cnt <= '0;
            else if (tdc_push)
                evt_cnt <= evt_cnt + 16'd1;
            // The rise edge counts as the first high cycle; losing ENABLE drops the pulse in flight.
            if (!tdc_enable) begin
                armed <= 1'b0;
            end else if (mon_rise) begin
                armed <= 1'b1;
                tot   <= 12'd1;
            end else if (mon_fall) begin
                armed <= 1'b0;
            end else if (mon_sync[1]) begin
                tot <= tot_inc(tot);
            end
        end
    end
`else
    logic unused_monhit;
    assign unused_monhit = MONHIT;
    assign tdc_push      = 1'b0;
    assign tdc_word      = 32'h0;
    assign tdc_rdata     = 8'h00;
`endif

    assign fifo_words = wr_ptr - rd_ptr;
    assign fifo_empty = (fifo_words == '0);
    assign fifo_full  = fifo_words[FIFO_AW];
    assign fifo_pop   = bus.BUS_RD && fifo_sel && (fifo_reg == 3'd7) && !fifo_empty;
    assign fifo_flush = bus.BUS_WR && fifo_sel && (fifo_reg == FIFO_CTRL_OFF);
    assign push_ok    = tdc_push && (!fifo_full || fifo_pop);
    assign byte_count = {{(21 - FIFO_AW){1'b0}}, fifo_words, 2'b00};
    assign head_word  = fifo_empty ? 32'h0 : fifo_mem[rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge BUS_CLK) begin
        if (push_ok)
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= tdc_word;
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST || fifo_flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (fifo_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (tdc_push && !push_ok)
                overflow <= 1'b1;
        end
    end

    // Upper count bytes come from the snapshot taken when byte 0 was read.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST)
            cnt_snap <= '0;
        else if (bus.BUS_RD && fifo_sel && (fifo_reg == FIFO_COUNT_OFF))
            cnt_snap <= byte_count[23:8];
    end

    always_comb begin
        fifo_rdata = 8'h00;
        case (fifo_reg)
            FIFO_CTRL_OFF:         fifo_rdata = {7'b0, overflow};
            FIFO_COUNT_OFF:        fifo_rdata = byte_count[7:0];
            FIFO_COUNT_OFF + 3'd1: fifo_rdata = cnt_snap[7:0];
            FIFO_COUNT_OFF + 3'd2: fifo_rdata = cnt_snap[15:8];
            default:               fifo_rdata = head_word[{fifo_reg[1:0], 3'b000} +: 8];
        endcase
    end

    always_comb begin
        rdata_mux = tdc_rdata;
        if (cmd_sel)
            rdata_mux = cmd_rdata;
        else if (fifo_sel)
            rdata_mux = fifo_rdata;
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST)
            bus.BUS_DATA_OUT <= 8'h00;
        else if (bus.BUS_RD)
            bus.BUS_DATA_OUT <= rdata_mux;
    end

endmodule

// File: tb/tb_multi_io_top.sv
// Directed bench for multi_io_top: sequencer patterns, external start, TDC/FIFO path (when MULTI_IO_TDC_EN) and resets.
`timescale 1ns/1ps
module tb_multi_io_top;

    localparam logic [15:0] CMD  = 16'h0000;
    localparam logic [15:0] FIFO = 16'h8100;
    localparam logic [15:0] TDC  = 16'h8700;
    localparam int          DEPTH = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ext_trigger = 1'b0;
    logic monhit = 1'b0;
    logic cmd_data, cmd_ready;
    int   n_checks = 0;
    int   n_fail = 0;

    multi_io_if bus_if ();

    multi_io_top dut (
        .BUS_CLK     (clk),
        .BUS_RST     (rst),
        .bus         (bus_if),
        .EXT_TRIGGER (ext_trigger),
        .MONHIT      (monhit),
        .CMD_DATA    (cmd_data),
        .CMD_READY   (cmd_ready)
    );

    always #10.5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
        @(posedge clk); #1;
        bus_if.BUS_ADD = addr; bus_if.BUS_DATA_IN = data; bus_if.BUS_WR = 1'b1;
        @(posedge clk); #1;
        bus_if.BUS_WR = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [7:0] data);
        @(posedge clk); #1;
        bus_if.BUS_ADD = addr; bus_if.BUS_RD = 1'b1;
        @(posedge clk); #1;
        bus_if.BUS_RD = 1'b0;
        data = bus_if.BUS_DATA_OUT;
    endtask

    task automatic read_count(output logic [23:0] c);
        logic [7:0] b0, b1, b2;
        bus_read(FIFO + 16'd1, b0);
        bus_read(FIFO + 16'd2, b1);
        bus_read(FIFO + 16'd3, b2);
        c = {b2, b1, b0};
    endtask

    task automatic read_word(output logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        bus_read(FIFO + 16'd4, b0);
        bus_read(FIFO + 16'd5, b1);
        bus_read(FIFO + 16'd6, b2);
        bus_read(FIFO + 16'd7, b3);
        w = {b3, b2, b1, b0};
    endtask

    // Shifts CMD_DATA in while CMD_READY is low; first bit ends up most significant.
    task automatic capture(input int restart_at, output logic [63:0] bits, output int len);
        bits = '0;
        len  = 0;
        while (cmd_ready == 1'b0 && len < 200) begin
            bits = {bits[62:0], cmd_data};
            len++;
            if (len == restart_at) begin
                bus_if.BUS_ADD = CMD + 16'd1; bus_if.BUS_WR = 1'b1;
            end
            @(posedge clk); #1;
            bus_if.BUS_WR = 1'b0;
        end
    endtask

    task automatic wait_busy(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (cmd_ready == 1'b0) seen = 1'b1;
        end
    endtask

    task automatic mon_pulse(input int hi_ns);
        @(negedge clk);
        monhit = 1'b1;
        #(hi_ns);
        monhit = 1'b0;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0]  rd;
        logic [23:0] cnt;
        logic [31:0] word;
        logic [63:0] bits;
        int          len;
        bit          seen;

        bus_if.BUS_ADD = '0; bus_if.BUS_DATA_IN = '0; bus_if.BUS_WR = 1'b0; bus_if.BUS_RD = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_val("reset_ready", 32'(cmd_ready), 32'h1);
        check_val("reset_cmd_data", 32'(cmd_data), 32'h0);
        check_val("reset_data_out", 32'(bus_if.BUS_DATA_OUT), 32'h0);
        bus_read(CMD + 16'd1, rd);  check_val("ready_reg", 32'(rd), 32'h1);
        bus_read(FIFO, rd);         check_val("reset_overflow", 32'(rd), 32'h0);
        read_count(cnt);            check_val("reset_count", 32'(cnt), 32'h0);

        // SIZE=9, single pass of B1 00
        bus_write(CMD + 16'd16, 8'hB1);
        bus_write(CMD + 16'd17, 8'h00);
        bus_write(CMD + 16'd3, 8'd9);
        bus_write(CMD + 16'd4, 8'd0);
        bus_read(CMD + 16'd16, rd);        check_val("mem0_readback", 32'(rd), 32'hB1);
        bus_read(CMD + 16'd80, rd);        check_val("mem_alias", 32'(rd), 32'hB1);
        bus_read(CMD + 16'd3, rd);         check_val("size_readback", 32'(rd), 32'd9);
        bus_write(CMD + 16'd1, 8'h00);
        capture(0, bits, len);
        check_val("seq9_len", 32'(len), 32'd9);
        check_val("seq9_bits", bits[31:0], 32'h162);
        check_val("seq9_idle_data", 32'(cmd_data), 32'h0);

        // 11101 x3 with a restart attempt mid-transfer
        bus_write(CMD + 16'd16, 8'hE8);
        bus_write(CMD + 16'd3, 8'd5);
        bus_write(CMD + 16'd5, 8'd3);
        bus_write(CMD + 16'd1, 8'h00);
        capture(4, bits, len);
        check_val("rep3_len", 32'(len), 32'd15);
        check_val("rep3_bits", bits[31:0], 32'h77BD);

        // SIZE=0 start is ignored
        bus_write(CMD + 16'd3, 8'd0);
        bus_write(CMD + 16'd1, 8'h00);
        wait_busy(6, seen);
        check_val("size0_ignored", 32'(seen), 32'h0);

        // external start
        bus_write(CMD + 16'd3, 8'd5);
        bus_write(CMD + 16'd5, 8'd0);
        bus_write(CMD + 16'd2, 8'd1);
        #5 ext_trigger = 1'b1;
        #25 ext_trigger = 1'b0;
        wait_busy(10, seen);
        check_val("ext_started", 32'(seen), 32'h1);
        capture(0, bits, len);
        check_val("ext_len", 32'(len), 32'd5);
        check_val("ext_bits", bits[31:0], 32'h1D);
        wait_busy(10, seen);
        check_val("ext_single", 32'(seen), 32'h0);
        bus_write(CMD + 16'd2, 8'd0);
        #5 ext_trigger = 1'b1;
        #25 ext_trigger = 1'b0;
        wait_busy(12, seen);
        check_val("ext_disabled", 32'(seen), 32'h0);

        // soft reset aborts a transfer
        bus_write(CMD + 16'd3, 8'd9);
        bus_write(CMD + 16'd1, 8'h00);
        repeat (2) @(posedge clk);
        bus_write(CMD + 16'd0, 8'h00);
        check_val("softrst_ready", 32'(cmd_ready), 32'h1);
        check_val("softrst_data", 32'(cmd_data), 32'h0);

        // empty FIFO reads
        for (int a = 4; a < 8; a++) begin
            bus_read(FIFO + 16'(a), rd);
            check_val($sformatf("empty_byte%0d", a), 32'(rd), 32'h0);
        end
        read_count(cnt);  check_val("empty_count", 32'(cnt), 32'h0);

`ifdef MULTI_IO_TDC_EN
        bus_write(TDC + 16'd1, 8'd1);
        bus_read(TDC + 16'd1, rd);  check_val("tdc_enable", 32'(rd), 32'h1);
        mon_pulse(150);
        mon_pulse(500);
        read_count(cnt);  check_val("tdc_count", 32'(cnt), 32'd8);
        read_word(word);  check_val("tdc_word0", word, 32'h4000_0007);
        read_word(word);  check_val("tdc_word1", word, 32'h4000_1018);
        read_count(cnt);  check_val("tdc_drained", 32'(cnt), 32'd0);

        // disable mid-pulse discards it; re-enable clears EVENT
        @(negedge clk);
        monhit = 1'b1;
        bus_write(TDC + 16'd1, 8'd0);
        monhit = 1'b0;
        repeat (5) @(posedge clk);
        read_count(cnt);  check_val("tdc_discard", 32'(cnt), 32'd0);
        bus_write(TDC + 16'd1, 8'd1);
        mon_pulse(63);
        read_word(word);  check_val("tdc_evt_clear", word, 32'h4000_0003);

        // overflow
        for (int i = 0; i < DEPTH + 1; i++) mon_pulse(63);
        read_count(cnt);  check_val("full_count", 32'(cnt), 32'(DEPTH * 4));
        bus_read(FIFO, rd);  check_val("overflow_set", 32'(rd), 32'h1);
        read_word(word);  check_val("full_head", word, 32'h4000_1003);
        bus_write(FIFO, 8'h00);
        read_count(cnt);  check_val("flush_count", 32'(cnt), 32'd0);
        bus_read(FIFO, rd);  check_val("overflow_clear", 32'(rd), 32'h0);
`else
        bus_write(TDC + 16'd1, 8'd1);
        bus_read(TDC + 16'd1, rd);  check_val("tdc_absent", 32'(rd), 32'h0);
        mon_pulse(150);
        read_count(cnt);  check_val("monhit_ignored", 32'(cnt), 32'd0);
        bus_read(FIFO, rd);  check_val("no_overflow", 32'(rd), 32'h0);
`endif

        // reset in the middle of SEND
        bus_write(CMD + 16'd3, 8'd9);
        bus_read(CMD + 16'd16, rd);  check_val("mem0_e8", 32'(rd), 32'hE8);
        bus_write(CMD + 16'd1, 8'h00);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_ready", 32'(cmd_ready), 32'h1);
        check_val("rst_cmd_data", 32'(cmd_data), 32'h0);
        check_val("rst_data_out", 32'(bus_if.BUS_DATA_OUT), 32'h0);
        rst = 1'b0;
        bus_read(CMD + 16'd3, rd);  check_val("rst_size", 32'(rd), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_io_top.md
Name: multi_io_top

Overview:
- Reduced readout controller for one FE-I4 channel, driven over an 8-bit register bus from the USB bridge.
- Contains a command sequencer that serialises a stored bit pattern onto CMD_DATA, started by a bus write or a synchronised external trigger.
- Contains a MONHIT time-over-threshold (ToT) measurement unit (TDC) and a 32-bit word FIFO that software reads byte-wise.
- Sits between the USB bus bridge and the FE command and monitor lines.

Parameters:
- MEM_BYTES, 64: command pattern memory size in bytes (power of 2).
- FIFO_DEPTH, 256: number of 32-bit FIFO words (power of 2).
- CMD_BASE, 16'h0000: command sequencer base address.
- FIFO_BASE, 16'h8100: FIFO base address.
- TDC_BASE, 16'h8700: TDC base address.

Ports:
- BUS_CLK in 1: single clock, about 48 MHz.
- BUS_RST in 1: synchronous, active-high reset.
- BUS_ADD in 16: register address.
- BUS_DATA_IN in 8: write data.
- BUS_DATA_OUT out 8: read data, registered.
- BUS_WR in 1: one-cycle write strobe, active-high.
- BUS_RD in 1: one-cycle read strobe, active-high.
- EXT_TRIGGER in 1: asynchronous external trigger.
- MONHIT in 1: asynchronous hit discriminator.
- CMD_DATA out 1: serial command stream, one bit per BUS_CLK.
- CMD_READY out 1: high when the sequencer is idle.

Behaviour:
- Reset values: BUS_DATA_OUT=0, CMD_DATA=0, CMD_READY=1. All registers are 0; the FIFO is empty with overflow cleared. Pattern memory is not cleared.
- Bus reads: BUS_DATA_OUT is valid the cycle after BUS_RD and holds until the next read. Unmapped reads return 0; unmapped writes are ignored.
- CMD_BASE register map:
  - +0 write: sequencer soft reset, which aborts any transfer and sets CMD_DATA=0.
  - +1 write: start (data ignored). +1 read: bit0 = CMD_READY.
  - +2: bit0 = EN_EXT_START.
  - +3/+4: SIZE in bits, little-endian 16-bit.
  - +5/+6: REPEAT, little-endian 16-bit.
  - +16 onward: pattern memory, readable and writable. Address offset is taken modulo MEM_BYTES.
- Sequencer states: IDLE, then SEND, then back to IDLE.
  - Start while IDLE with SIZE>0: CMD_READY falls on the next cycle, and bit 0 appears on CMD_DATA that same cycle.
  - Bit order: byte 0 first, MSB first within each byte.
  - Each pass emits SIZE bits. Passes = max(REPEAT,1), sent back-to-back with no gap.
  - After the last bit, CMD_DATA=0 and CMD_READY=1 on the following cycle.
  - Start with SIZE=0 is ignored.
  - Start while in SEND is ignored.
  - Writes to registers during SEND take effect on the next start.
- External start:
  - EXT_TRIGGER passes through a 2-flop synchroniser plus edge detector.
  - A rising edge with EN_EXT_START=1 and the sequencer IDLE equals a start.
  - Edges while busy are dropped.
  - If a bus start and an external start occur in the same cycle, one transfer is made.
- TDC_BASE register map: +1 bit0 = ENABLE.
- TDC measurement:
  - MONHIT passes through a 2-flop synchroniser.
  - A rising edge with ENABLE=1 clears the ToT counter. The counter increments every cycle while high and saturates at 4095.
  - A falling edge writes the word {4'h4, EVENT[15:0], TOT[11:0]} to the FIFO, then EVENT increments (wraps at 16 bits).
  - A pulse shorter than one BUS_CLK may be missed. A pulse of at least 2 cycles is always recorded, with TOT equal to the synchronised high-cycle count.
  - Clearing ENABLE mid-pulse discards that pulse.
  - Writing +1 with bit0=1 also clears EVENT.
- FIFO_BASE register map:
  - +0 write: flush FIFO and clear overflow. +0 read: bit0 = overflow (sticky).
  - +1..+3 read: byte count = words×4, 24-bit little-endian, sampled as a coherent snapshot at the +1 read.
  - +4..+7 read: head-word bytes, LSB first. Reading +7 pops one word.
  - Reading an empty FIFO returns 0 and does not pop.
- FIFO boundaries:
  - A write while full drops the word and sets overflow.
  - A simultaneous pop and write while full accepts the write.
- BUS_RST mid-transfer: everything returns to reset values on the next edge.

Optional Feature:
- Macro: MULTI_IO_TDC_EN.
- Defined: the TDC and its registers are present as described above.
- Undefined: MONHIT is ignored, TDC_BASE reads return 0, and the FIFO never receives words. FIFO registers still operate normally.

Decomposition:
- Package multi_io_pkg holds:
  - Register offsets: CMD start/size/repeat/data offsets 1/3/5/16, FIFO count/data offsets 1/4.
  - TDC_HEADER = 4'h4 and TOT_MAX = 4095.
  - Sequencer state enum.
- Sub-module multi_io_cmd_seq: pattern memory, SIZE/REPEAT registers, serialiser, CMD_READY. The top keeps bus decode, TDC and FIFO.

Test Plan:
- SIZE=9, REPEAT=0, mem[0]=8'hB1, mem[1]=8'h00, start → CMD_DATA emits 1,0,1,1,0,0,0,1,0 on consecutive cycles; CMD_READY is low for exactly 9 cycles.
- SIZE=5, mem[0]=8'hE8, REPEAT=3, start → pattern 11101 repeated 3 times back-to-back (15 cycles). A second start mid-transfer changes nothing.
- EN_EXT_START=1, SIZE=5, 25 ns EXT_TRIGGER pulse → exactly one transfer. With EN_EXT_START=0 → no transfer.
- TDC enabled; MONHIT high for 150 ns, then for 500 ns → FIFO count reads 8. Words have header 4, EVENT 0 and 1, and TOT ≈7 and ≈24 (±1).
- Fill FIFO_DEPTH+1 words → count = FIFO_DEPTH×4 and overflow=1. Write +0 → count 0, overflow 0.
- Reading the empty FIFO at +4..+7 → all return 0 and count stays 0. BUS_RST during SEND → CMD_DATA=0 and CMD_READY=1 on the next cycle.
